piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that takes a WIDTH-bit word over a valid/ready load handshake and drives it MSB-first onto a one-bit serial line, one bit per clock. It is the sending end for the shift-register datapath blocks: its serial_out connects directly to a SISO/SIPO register's serial_in. A configurable idle gap is inserted between frames. Frame-start and valid qualifiers let the receiving side align words.

---
 rtl/piso_serializer.sv | 199 +++++++++++++++++++
 tb/tb_piso_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and sent MSB first on serial_out, one bit per clock.
// After each frame, GAP idle cycles (serial_valid=0) are inserted before the
// next frame may start. With GAP=0 and a word always waiting, the output is a
// continuous bit stream with no idle cycles.
//
// Parameters
//   WIDTH        bits per word (2..32)
//   GAP          idle cycles between frames (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   data_in      word to send, sampled only when a load is accepted
//   load_valid   data_in holds a word to send
//   load_ready   a word can be accepted this cycle (combinational)
//   serial_out   registered serial data, MSB first, 0 when idle
//   serial_valid registered, high on every cycle that carries a frame bit
//   frame_start  registered, high on the cycle carrying bit WIDTH-1
//   busy         registered, high while shifting or in the gap
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [CW-1:0]    BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    BIT_ZERO = CW'(0);
  localparam logic [CW-1:0]    BIT_ONE  = CW'(1);
  localparam logic [3:0]       GAP_LOAD = 4'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic             GAP_EN   = (GAP > 0) ? 1'b1 : 1'b0;
  localparam logic [WIDTH-1:0] SH_ZERO  = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Registered state
  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [3:0]       gap_cnt_r;
  logic             serial_out_r;
  logic             serial_valid_r;
  logic             frame_start_r;
  logic             busy_r;

  // Next-state values
  state_t           state_s;
  logic [WIDTH-1:0] shreg_s;
  logic [CW-1:0]    bit_cnt_s;
  logic [3:0]       gap_cnt_s;
  logic             serial_out_s;
  logic             serial_valid_s;
  logic             frame_start_s;
  logic             busy_s;
  logic             ready_s;
  logic             accept_s;

  // Ready decode: open only in idle or on the final cycle before the line frees up
  always_comb begin
    ready_s = 1'b0;
    if (rst) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  ready_s = 1'b1;
        // A new word can follow the last bit directly only when no gap is configured
        ST_SHIFT: ready_s = (bit_cnt_r == BIT_ZERO) && !GAP_EN;
        ST_GAP:   ready_s = (gap_cnt_r == 4'd0);
        default:  ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s   = load_valid && ready_s;
  assign load_ready = ready_s;

  // Next-state logic for the frame sequencer and datapath
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bit_cnt_s = bit_cnt_r;
    gap_cnt_s = gap_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s   = ST_SHIFT;
          shreg_s   = data_in;
          bit_cnt_s = BIT_LAST;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_r != BIT_ZERO) begin
          shreg_s   = {shreg_r[WIDTH-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r - BIT_ONE;
        end else if (GAP_EN) begin
          state_s   = ST_GAP;
          shreg_s   = SH_ZERO;
          gap_cnt_s = GAP_LOAD;
        end else if (accept_s) begin
          shreg_s   = data_in;
          bit_cnt_s = BIT_LAST;
        end else begin
          state_s   = ST_IDLE;
          shreg_s   = SH_ZERO;
        end
      end

      ST_GAP: begin
        if (gap_cnt_r != 4'd0) begin
          gap_cnt_s = gap_cnt_r - 4'd1;
        end else if (accept_s) begin
          state_s   = ST_SHIFT;
          shreg_s   = data_in;
          bit_cnt_s = BIT_LAST;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      default: begin
        state_s   = ST_IDLE;
        shreg_s   = SH_ZERO;
        bit_cnt_s = BIT_ZERO;
        gap_cnt_s = 4'd0;
      end
    endcase
  end

  // Output decode from the next state so every output is a plain register
  always_comb begin
    serial_valid_s = 1'b0;
    serial_out_s   = 1'b0;
    frame_start_s  = 1'b0;
    busy_s         = 1'b0;
    if (state_s == ST_SHIFT) begin
      serial_valid_s = 1'b1;
      // The bit shown is always the MSB of the (next) shift register
      serial_out_s   = shreg_s[WIDTH-1];
    end else begin
      serial_valid_s = 1'b0;
      serial_out_s   = 1'b0;
    end
    // Every accept starts a frame on the following cycle
    frame_start_s = accept_s;
    busy_s        = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      shreg_r        <= SH_ZERO;
      bit_cnt_r      <= BIT_ZERO;
      gap_cnt_r      <= 4'd0;
      serial_out_r   <= 1'b0;
      serial_valid_r <= 1'b0;
      frame_start_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      shreg_r        <= shreg_s;
      bit_cnt_r      <= bit_cnt_s;
      gap_cnt_r      <= gap_cnt_s;
      serial_out_r   <= serial_out_s;
      serial_valid_r <= serial_valid_s;
      frame_start_r  <= frame_start_s;
      busy_r         <= busy_s;
    end
  end

  assign serial_out   = serial_out_r;
  assign serial_valid = serial_valid_r;
  assign frame_start  = frame_start_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Three instances: a (WIDTH=4, GAP=0), b (WIDTH=4, GAP=2), c (WIDTH=8, GAP=0).
// Expected serial bits are queued whenever a word is loaded; a negedge monitor
// pops and compares them whenever serial_valid is high and otherwise requires
// an idle line. Directed checks cover handshake and timing corner cases.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] d_a, d_b;
  logic [7:0] d_c;
  logic       lv_a, lv_b, lv_c;
  logic       lr_a, lr_b, lr_c;
  logic       so_a, so_b, so_c;
  logic       sv_a, sv_b, sv_c;
  logic       fs_a, fs_b, fs_c;
  logic       bz_a, bz_b, bz_c;

  piso_serializer #(.WIDTH(4), .GAP(0)) ua (
    .clk(clk), .rst(rst), .data_in(d_a), .load_valid(lv_a), .load_ready(lr_a),
    .serial_out(so_a), .serial_valid(sv_a), .frame_start(fs_a), .busy(bz_a));

  piso_serializer #(.WIDTH(4), .GAP(2)) ub (
    .clk(clk), .rst(rst), .data_in(d_b), .load_valid(lv_b), .load_ready(lr_b),
    .serial_out(so_b), .serial_valid(sv_b), .frame_start(fs_b), .busy(bz_b));

  piso_serializer #(.WIDTH(8), .GAP(0)) uc (
    .clk(clk), .rst(rst), .data_in(d_c), .load_valid(lv_c), .load_ready(lr_c),
    .serial_out(so_c), .serial_valid(sv_c), .frame_start(fs_c), .busy(bz_c));

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  typedef struct {
    logic [7:0] word;
    logic [7:0] junk;
    logic [7:0] seq;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the first nbits of a word, MSB first; the first one carries frame_start
  task automatic push_word(input int which, input logic [31:0] w, input int width, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      exp_t e;
      e.b  = w[width-1-i];
      e.fs = (i == 0);
      case (which)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input string nm, input logic sv, input logic so, input logic fs,
                     input bit have, input exp_t e);
    if (sv === 1'b1) begin
      n_cmp++;
      if (!have) begin
        n_bad++;
        $display("FAIL %s_unexpected_bit: got serial_valid=1 with out=%0b, expected no frame bit (t=%0t)",
                 nm, so, $time);
      end else begin
        n_cmp--;
        check({nm, "_bit"}, so, e.b);
        check({nm, "_frame_start"}, fs, e.fs);
      end
    end else begin
      check({nm, "_idle_line"}, {sv, so, fs}, 3'b000);
    end
  endtask

  // Scoreboard monitor: pops one expected bit per valid output cycle
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      bit   have;
      have = (q_a.size() > 0);
      e = (have && sv_a === 1'b1) ? q_a.pop_front() : '0;
      mon("a", sv_a, so_a, fs_a, have, e);
      have = (q_b.size() > 0);
      e = (have && sv_b === 1'b1) ? q_b.pop_front() : '0;
      mon("b", sv_b, so_b, fs_b, have, e);
      have = (q_c.size() > 0);
      e = (have && sv_c === 1'b1) ? q_c.pop_front() : '0;
      mon("c", sv_c, so_c, fs_c, have, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{word: 8'h81, junk: 8'hFF, seq: 8'b1000_0001};
    tbl[1] = '{word: 8'hA5, junk: 8'h5A, seq: 8'b1010_0101};
    tbl[2] = '{word: 8'h3C, junk: 8'hC3, seq: 8'b0011_1100};
    tbl[3] = '{word: 8'h00, junk: 8'hFF, seq: 8'b0000_0000};
    tbl[4] = '{word: 8'hFF, junk: 8'h00, seq: 8'b1111_1111};

    rst  = 1'b1;
    lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
    d_a  = 4'h0; d_b  = 4'h0; d_c  = 8'h00;

    // Reset held for two cycles
    step();
    step();
    mon_en = 1'b1;
    check("rst_outputs_c", {so_c, sv_c, fs_c, bz_c}, 4'b0000);
    check("rst_ready_c", lr_c, 1'b0);
    check("rst_ready_a", lr_a, 1'b0);

    // Reset and load at the same edge: reset wins
    lv_a = 1'b1; d_a = 4'hF;
    step();
    check("rst_vs_load_valid", sv_a, 1'b0);
    check("rst_vs_load_busy", bz_a, 1'b0);
    lv_a = 1'b0;
    rst  = 1'b0;
    #1;
    check("release_ready_a", lr_a, 1'b1);
    check("release_ready_b", lr_b, 1'b1);
    check("release_ready_c", lr_c, 1'b1);

    // Single frame on a
    d_a = 4'b1101; lv_a = 1'b1;
    push_word(0, 32'(4'b1101), 4, 4);
    step();
    lv_a = 1'b0; d_a = 4'h0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      check("single_valid", sv_a, 1'b1);
      check("single_fs", fs_a, (j == 0) ? 1'b1 : 1'b0);
      check("single_ready", lr_a, (j == 3) ? 1'b1 : 1'b0);
    end
    step();
    check("single_end_valid", sv_a, 1'b0);
    check("single_end_busy", bz_a, 1'b0);
    check("single_end_ready", lr_a, 1'b1);

    // Back-to-back frames on a, no bubble
    d_a = 4'b1101; lv_a = 1'b1;
    push_word(0, 32'(4'b1101), 4, 4);
    step();
    d_a = 4'b0110;
    push_word(0, 32'(4'b0110), 4, 4);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      check("b2b_valid", sv_a, 1'b1);
      check("b2b_fs", fs_a, (j % 4 == 0) ? 1'b1 : 1'b0);
      if (j == 4) lv_a = 1'b0;
    end
    step();
    check("b2b_end_valid", sv_a, 1'b0);
    check("b2b_end_busy", bz_a, 1'b0);

    // Two frames on b separated by a two-cycle gap
    d_b = 4'b1101; lv_b = 1'b1;
    push_word(1, 32'(4'b1101), 4, 4);
    step();
    d_b = 4'b0110;
    push_word(1, 32'(4'b0110), 4, 4);
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      check("gap_valid", sv_b, (j < 4 || j >= 6) ? 1'b1 : 1'b0);
      check("gap_ready", lr_b, (j == 5) ? 1'b1 : 1'b0);
      check("gap_fs", fs_b, (j == 0 || j == 6) ? 1'b1 : 1'b0);
      check("gap_busy", bz_b, 1'b1);
      if (j == 6) lv_b = 1'b0;
    end
    step();
    check("gap_tail1_busy", bz_b, 1'b1);
    check("gap_tail1_ready", lr_b, 1'b0);
    step();
    check("gap_tail2_ready", lr_b, 1'b1);
    check("gap_tail2_valid", sv_b, 1'b0);
    step();
    check("gap_tail3_busy", bz_b, 1'b0);

    // Mid-frame reset on c after three bits, then a full frame
    d_c = 8'hA5; lv_c = 1'b1;
    push_word(2, 32'(8'hA5), 8, 3);
    step();
    lv_c = 1'b0;
    step();
    step();
    check("midrst_before_valid", sv_c, 1'b1);
    rst = 1'b1;
    step();
    check("midrst_valid", sv_c, 1'b0);
    check("midrst_out", so_c, 1'b0);
    check("midrst_busy", bz_c, 1'b0);
    check("midrst_ready", lr_c, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", lr_c, 1'b1);
    d_c = 8'h3C; lv_c = 1'b1;
    push_word(2, 32'(8'h3C), 8, 8);
    step();
    lv_c = 1'b0;
    repeat (7) step();
    check("after_rst_last_valid", sv_c, 1'b1);
    step();
    check("after_rst_end_valid", sv_c, 1'b0);

    // Table: ignored load pulse and data_in change while a frame is in flight
    for (int r = 0; r < 5; r++) begin
      d_c = tbl[r].word; lv_c = 1'b1;
      push_word(2, 32'(tbl[r].seq), 8, 8);
      step();
      lv_c = 1'b0;
      check("tbl_fs", fs_c, 1'b1);
      for (int j = 1; j < 8; j++) begin
        step();
        if (j == 2) begin
          d_c = tbl[r].junk; lv_c = 1'b1;
          check("tbl_busy_ready", lr_c, 1'b0);
        end
        if (j == 3) lv_c = 1'b0;
        check("tbl_busy", bz_c, 1'b1);
      end
      step();
      check("tbl_end_valid", sv_c, 1'b0);
      check("tbl_end_ready", lr_c, 1'b1);
      check("tbl_end_busy", bz_c, 1'b0);
    end

    step();
    step();
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    check("q_c_drained", q_c.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
